// File: rtl/ser_arb_pkg.sv
// Shared types and default sizing for the serial lane arbiter.
package ser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int N_LANES     = 4;
  localparam int ARB_TIMEOUT = 64;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting lane at or after ptr, wrapping mod N.
import ser_arb_pkg::*;

module rr_pick #(
  parameter int N  = N_LANES,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   tmp;
  int             off;
  int             sum;

  // Rotate so bit 0 is the lane at ptr; the lowest set bit is the winner.
  always_comb begin
    found = |req;
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    tmp   = '0;
    off   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      tmp = rot >> i;
      if (tmp[0]) off = i;
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    idx = PW'(sum);
  end

endmodule

// File: rtl/ser_lane_arbiter.sv
// Shares one serial detector between N lanes with round-robin grants,
// frame-based release and a grant timeout.
import ser_arb_pkg::*;

// state   | meaning
// IDLE    | no grant; pick next requesting lane from ptr
// GRANT   | lane granted, waiting for detector valid or timeout
// XFER    | detector frame in progress; hold grant until valid falls
// RELEASE | grant dropped for one cycle; ptr moved past served lane
module ser_lane_arbiter #(
  parameter int N       = N_LANES,
  parameter int TIMEOUT = ARB_TIMEOUT,
  parameter int PW      = $clog2(N),
  parameter int TW      = $clog2(TIMEOUT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic [N-1:0] req,
  input  logic [N-1:0] lane_ser_in,
  input  logic         det_ser_out,
  input  logic         det_ser_out_valid,
  output logic         det_ser_in,
  output logic [N-1:0] grant,
  output logic         lane_ser_out,
  output logic [N-1:0] lane_valid,
  output logic         busy,
  output logic         timeout_pulse
);

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [TW-1:0] timer;

  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic [PW-1:0] next_ptr;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
  assign next_ptr    = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      grant         <= '0;
      ptr           <= '0;
      gidx          <= '0;
      timer         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      if (clk_en) begin
        case (state)
          IDLE: begin
            if (pick_found) begin
              grant <= pick_onehot;
              gidx  <= pick_idx;
              timer <= '0;
              state <= GRANT;
            end
          end
          GRANT: begin
            if (det_ser_out_valid) begin
              state <= XFER;
            end else if (!req[gidx]) begin
              grant <= '0;
              ptr   <= next_ptr;
              state <= RELEASE;
            end else if (timer == TW'(TIMEOUT - 1)) begin
              grant         <= '0;
              ptr           <= next_ptr;
              timeout_pulse <= 1'b1;
              state         <= RELEASE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          XFER: begin
            if (!det_ser_out_valid) begin
              grant <= '0;
              ptr   <= next_ptr;
              state <= RELEASE;
            end
          end
          RELEASE: begin
            state <= IDLE;
          end
          default: begin
            grant <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign det_ser_in   = |(lane_ser_in & grant);
  assign lane_ser_out = det_ser_out;
  assign lane_valid   = {N{det_ser_out_valid}} & grant;
  assign busy         = (state != IDLE);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));

endmodule

// File: doc/ser_lane_arbiter.md
Name: ser_lane_arbiter

Overview:
- Round-robin arbiter that shares one serial sequence-detector/counter datapath between N independent serial lanes.
- Grants one lane at a time and routes that lane's serial stream into the detector.
- Holds the grant until the detector finishes one output frame (valid falls) or a timeout expires.
- Steers the detector's serial output back to the granted lane.
- Sits between the lane receivers and the single shared detector instance.

Parameters:
- N, 4, number of requesting serial lanes (2..8).
- TIMEOUT, 64, enabled cycles allowed in GRANT before the detector must raise valid.
- PW, $clog2(N), width of the round-robin pointer.
- TW, $clog2(TIMEOUT), width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  global enable; all state advances only when 1.
- req  in  N  per-lane request; a level held while the lane has data.
- lane_ser_in  in  N  per-lane serial data.
- det_ser_out  in  1  serial output from the shared detector.
- det_ser_out_valid  in  1  frame-valid from the shared detector.
- det_ser_in  out  1  serial input driven to the shared detector.
- grant  out  N  one-hot grant, registered.
- lane_ser_out  out  1  copy of det_ser_out.
- lane_valid  out  N  per-lane valid.
- busy  out  1  1 whenever state is not IDLE.
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, ptr=0, timer=0, timeout_pulse=0, busy=0. This applies mid-frame too: the grant drops immediately.
- clk_en=0: state, ptr, timer and grant are frozen. Combinational steering still follows the held grant.
- Combinational outputs:
  - det_ser_in = lane_ser_in[k] when grant[k]=1; 0 when grant=0.
  - lane_ser_out = det_ser_out.
  - lane_valid[k] = det_ser_out_valid & grant[k]; all 0 when grant=0.
- States (each transition requires clk_en=1):
  - IDLE:
    - If req=0, stay.
    - Otherwise pick the first lane with req=1 searching ptr, ptr+1, ..., wrapping mod N.
    - Set grant to that one-hot, timer=0, go GRANT. Grant is visible the cycle after req is sampled (1-cycle latency).
  - GRANT:
    - If det_ser_out_valid=1, go XFER. Valid has priority over the other conditions in the same cycle.
    - Else if req[granted]=0 (lane withdrew), go RELEASE, no pulse.
    - Else if timer==TIMEOUT-1, go RELEASE and assert timeout_pulse for that transition cycle.
    - Else timer+1.
  - XFER:
    - Hold the grant while det_ser_out_valid=1; req changes are ignored.
    - On the valid 1->0 edge, go RELEASE.
  - RELEASE:
    - grant=0, ptr=(granted index+1) mod N, go IDLE.
    - Exactly one cycle, giving the detector one cycle with det_ser_in=0 between lanes.
- Fairness: after lane k is served, lane k gets lowest priority. Any requesting lane is granted within N-1 other grants.
- Wrap-around: the ptr increment wraps N-1 -> 0. Timer never exceeds TIMEOUT-1.
- grant is always one-hot or zero; any other value is a design error, to be flagged by an assertion.

Decomposition:
- Shared package ser_arb_pkg:
  - state enum {IDLE, GRANT, XFER, RELEASE}.
  - Default constants N_LANES=4, ARB_TIMEOUT=64.
- Sub-module rr_pick: combinational; inputs req[N], ptr[PW]; outputs found, idx[PW].
- The FSM, timer and steering stay in ser_lane_arbiter.

Test Plan:
- Single lane: req=4'b0010, detector raises valid 5 cycles after grant and holds it 3 cycles -> grant=0010 one cycle after req; lane_valid=0010 during those 3 cycles; grant=0 in the RELEASE cycle; ptr=2.
- Round-robin: req=4'b1111 held, each frame completes -> grant sequence 0001,0010,0100,1000,0001 with one zero-grant cycle between each.
- Timeout: req=4'b0100, valid never rises, TIMEOUT=64 -> grant held 64 enabled cycles; timeout_pulse=1 for exactly one cycle; grant cleared; next pick starts at lane 3.
- Withdraw: grant on lane 1, req[1] dropped in GRANT -> RELEASE next cycle, timeout_pulse stays 0. Same drop in XFER -> grant held until valid falls.
- clk_en gating: clk_en=0 for 10 cycles mid-GRANT -> timer and state unchanged; timeout occurs 10 cycles later in wall time.
- Async reset: rst=0 asserted mid-XFER between clock edges -> grant, busy and lane_valid go 0 immediately; after release, ptr=0 and lane 0 is chosen first when req=1111.
